// File: rtl/spect_mel_binner.sv
// spect_mel_binner: accumulates one frame of FFT magnitude bins (0..255) into
// mel bands. Each bin's band is looked up through an external position table
// (registered read, one cycle latency) and shifted down by BAND_SHIFT.
// Exactly 256 >> BAND_SHIFT band sums are emitted per frame, in ascending order.
// Optional macro MEL_BIN_SAT_EN: band accumulator saturates instead of wrapping.
module spect_mel_binner #(
  parameter int MAG_W      = 16,
  parameter int ACC_W      = 24,
  parameter int BAND_SHIFT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W-1:0] in_mag,
  input  logic             in_last,
  output logic [7:0]       table_addr,
  input  logic [7:0]       table_data,
  output logic             out_valid,
  output logic [7:0]       out_band,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_last
);

  localparam int         NUM_BANDS = 256 >> BAND_SHIFT;
  localparam logic [7:0] LAST_BAND = 8'(NUM_BANDS - 1);

  typedef enum logic [1:0] {ACCUM, DRAIN, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [7:0]         bin_cnt, bin_cnt_d;
  logic               p1_valid, p1_valid_d;
  logic [MAG_W-1:0]   p1_mag, p1_mag_d;
  logic [7:0]         cur_band, cur_band_d;
  logic [ACC_W-1:0]   acc, acc_d;
  logic               out_valid_d, out_last_d, in_ready_d;
  logic [7:0]         out_band_d;
  logic [ACC_W-1:0]   out_sum_d;

  logic               accept;
  logic [7:0]         band;
  logic [ACC_W-1:0]   mag_ext;
  logic [ACC_W-1:0]   acc_add;

  assign table_addr = bin_cnt;
  assign accept     = in_valid && in_ready;
  assign band       = table_data >> BAND_SHIFT;
  assign mag_ext    = ACC_W'(p1_mag);

`ifdef MEL_BIN_SAT_EN
  logic [ACC_W:0] acc_wide;
  assign acc_wide = {1'b0, acc} + {1'b0, mag_ext};
  assign acc_add  = acc_wide[ACC_W] ? '1 : acc_wide[ACC_W-1:0];
`else
  assign acc_add  = acc + mag_ext;
`endif

  // Next-state, pipeline and emission logic.
  // The last bin's band is never emitted in DRAIN itself: DRAIN only folds it
  // into acc (emitting the previous band if the band changed), and FLUSH then
  // emits cur_band onward, so at most one emission happens per cycle.
  always_comb begin
    state_d     = state_q;
    bin_cnt_d   = bin_cnt;
    p1_valid_d  = 1'b0;
    p1_mag_d    = p1_mag;
    cur_band_d  = cur_band;
    acc_d       = acc;
    out_valid_d = 1'b0;
    out_band_d  = out_band;
    out_sum_d   = out_sum;
    out_last_d  = 1'b0;
    in_ready_d  = in_ready;

    if (p1_valid) begin
      if (band == cur_band) begin
        acc_d = acc_add;
      end else begin
        out_valid_d = 1'b1;
        out_band_d  = cur_band;
        out_sum_d   = acc;
        cur_band_d  = band;
        acc_d       = mag_ext;
      end
    end

    case (state_q)
      ACCUM: begin
        if (accept) begin
          p1_valid_d = 1'b1;
          p1_mag_d   = in_mag;
          bin_cnt_d  = bin_cnt + 8'd1;
          if (in_last || bin_cnt == 8'd255) begin
            state_d    = DRAIN;
            in_ready_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        state_d = FLUSH;
      end
      FLUSH: begin
        out_valid_d = 1'b1;
        out_band_d  = cur_band;
        out_sum_d   = acc;
        acc_d       = '0;
        if (cur_band == LAST_BAND) begin
          out_last_d = 1'b1;
          state_d    = ACCUM;
          bin_cnt_d  = '0;
          cur_band_d = '0;
        end else begin
          cur_band_d = cur_band + 8'd1;
        end
      end
      default: state_d = ACCUM;
    endcase

    if (out_valid && out_last) in_ready_d = 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACCUM;
      bin_cnt   <= '0;
      p1_valid  <= 1'b0;
      p1_mag    <= '0;
      cur_band  <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_band  <= '0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_q   <= state_d;
      bin_cnt   <= bin_cnt_d;
      p1_valid  <= p1_valid_d;
      p1_mag    <= p1_mag_d;
      cur_band  <= cur_band_d;
      acc       <= acc_d;
      out_valid <= out_valid_d;
      out_band  <= out_band_d;
      out_sum   <= out_sum_d;
      out_last  <= out_last_d;
      in_ready  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_spect_mel_binner.sv
// Bench for spect_mel_binner: a default-width instance and an ACC_W=17
// instance share stimulus; each has its own position table and scoreboard.
module tb_spect_mel_binner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_mag = '0;
  logic        in_last = 1'b0;

  logic        in_ready, out_valid, out_last;
  logic [7:0]  table_addr, out_band;
  logic [7:0]  table_data = '0;
  logic [23:0] out_sum;

  logic        rdy17, ov17, ol17;
  logic [7:0]  addr17, ob17;
  logic [7:0]  tdata17 = '0;
  logic [16:0] os17;

  int          nvec = 0;
  int          nmis = 0;
  bit          chk_rdy = 0;

  logic [7:0]  tbl [256];
  int unsigned mag_v [256];
  int          cnt [32] = '{2,2,3,2,3,3,3,4,4,5,5,6,6,6,6,7,7,7,7,
                            10,10,10,10,13,13,13,13,15,15,15,15,16};

  typedef struct {int band; longint sum; bit last;} exp_t;
  exp_t q24 [$];
  exp_t q17 [$];

  always #5 clk = ~clk;

  spect_mel_binner #(.MAG_W(16), .ACC_W(24), .BAND_SHIFT(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mag(in_mag), .in_last(in_last), .table_addr(table_addr),
    .table_data(table_data), .out_valid(out_valid), .out_band(out_band),
    .out_sum(out_sum), .out_last(out_last));

  spect_mel_binner #(.MAG_W(16), .ACC_W(17), .BAND_SHIFT(3)) dut17 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy17),
    .in_mag(in_mag), .in_last(in_last), .table_addr(addr17),
    .table_data(tdata17), .out_valid(ov17), .out_band(ob17),
    .out_sum(os17), .out_last(ol17));

  // Registered-read position table models.
  always @(posedge clk) begin
    table_data <= tbl[table_addr];
    tdata17    <= tbl[addr17];
  end

  // Monitor for the 24-bit instance, plus in_ready release timing.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && chk_rdy) begin
      nvec++;
      chk_rdy = 0;
      if (in_ready !== 1'b1) begin
        nmis++;
        $display("FAIL rdy_release: in_ready=%0b, required 1", in_ready);
      end
    end
    if (!rst && out_valid) begin
      nvec++;
      if (q24.size() == 0) begin
        nmis++;
        $display("FAIL out24_unexpected: band=%0d sum=%0d last=%0b, required no strobe",
                 out_band, out_sum, out_last);
      end else begin
        e = q24.pop_front();
        if (out_band != e.band || out_sum != e.sum || out_last != e.last) begin
          nmis++;
          $display("FAIL out24: band=%0d sum=%0d last=%0b, required band=%0d sum=%0d last=%0b",
                   out_band, out_sum, out_last, e.band, e.sum, e.last);
        end
      end
      if (out_last) begin
        nvec++;
        if (in_ready !== 1'b0) begin
          nmis++;
          $display("FAIL rdy_at_last: in_ready=%0b, required 0", in_ready);
        end
        chk_rdy = 1;
      end
    end
  end

  // Monitor for the 17-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ov17) begin
      nvec++;
      if (q17.size() == 0) begin
        nmis++;
        $display("FAIL out17_unexpected: band=%0d sum=%0d, required no strobe", ob17, os17);
      end else begin
        e = q17.pop_front();
        if (ob17 != e.band || os17 != e.sum || ol17 != e.last) begin
          nmis++;
          $display("FAIL out17: band=%0d sum=%0d last=%0b, required band=%0d sum=%0d last=%0b",
                   ob17, os17, ol17, e.band, e.sum, e.last);
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push_sums(input longint s [32]);
    exp_t e;
    for (int k = 0; k < 32; k++) begin
      e.band = k;
      e.last = (k == 31);
      e.sum  = s[k] % (64'd1 << 24);
      q24.push_back(e);
`ifdef MEL_BIN_SAT_EN
      e.sum = (s[k] > 131071) ? 131071 : s[k];
`else
      e.sum = s[k] % 131072;
`endif
      q17.push_back(e);
    end
  endtask

  task automatic push_model(input int nb);
    longint s [32];
    for (int k = 0; k < 32; k++) s[k] = 0;
    for (int b = 0; b < nb; b++) s[tbl[b] >> 3] += mag_v[b];
    push_sums(s);
  endtask

  task automatic send_bin(input logic [15:0] mag, input logic last);
    int g = 0;
    in_valid = 1'b1;
    in_mag   = mag;
    in_last  = last;
    while (!in_ready) begin
      @(negedge clk);
      g++;
      if (g > 2000) begin
        $display("FAIL accept_timeout: in_ready stuck at 0, required 1");
        $fatal(1, "accept timeout");
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int nb, input bit last_flag, input bit gaps);
    for (int b = 0; b < nb; b++) begin
      send_bin(mag_v[b][15:0], last_flag && (b == nb - 1));
      if (gaps && $urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((q24.size() != 0 || q17.size() != 0) && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 1000) begin
      nvec++;
      nmis++;
      $display("FAIL drain_timeout: pending=%0d, required 0", q24.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    longint s [32];
    int idx = 0;
    for (int k = 0; k < 32; k++)
      for (int i = 0; i < cnt[k]; i++) begin
        tbl[idx] = 8'(k * 8 + (i * 8) / cnt[k]);
        idx++;
      end

    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_band", out_band, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_table_addr", table_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    // All-ones full frame, implicit last on bin 255.
    for (int b = 0; b < 256; b++) mag_v[b] = 1;
    push_model(256);
    send_frame(256, 0, 0);
    wait_drain();

    // Short frame: bins 0..9, in_last on bin 9; hand-derived sums.
    for (int k = 0; k < 32; k++) s[k] = 0;
    s[0] = 2; s[1] = 2; s[2] = 3; s[3] = 2; s[4] = 1;
    push_sums(s);
    send_frame(10, 1, 0);
    chk("rdy_after_last_accept", in_ready, 0);
    chk("addr_after_last_accept", table_addr, 10);
    wait_drain();
    chk("addr_after_frame", table_addr, 0);

    // Random magnitudes with random bubbles.
    for (int b = 0; b < 256; b++) mag_v[b] = $urandom_range(0, 65535);
    push_model(256);
    send_frame(256, 0, 1);
    wait_drain();

    // Maximum magnitudes: exercises 17-bit wrap/saturate.
    for (int b = 0; b < 256; b++) mag_v[b] = 65535;
    push_model(256);
    send_frame(256, 0, 0);
    wait_drain();

    // Reset after bin 100, then a clean all-ones frame.
    for (int b = 0; b < 256; b++) mag_v[b] = 1;
    push_model(256);
    send_frame(101, 0, 0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_table_addr", table_addr, 0);
    chk("midrst_in_ready", in_ready, 1);
    q24.delete();
    q17.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_model(256);
    send_frame(256, 0, 0);
    wait_drain();

    // Two back-to-back frames, valid held high; second ends with in_last on 255.
    push_model(256);
    push_model(256);
    send_frame(256, 0, 0);
    in_valid = 1'b1;
    send_frame(256, 1, 0);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
